// File: rtl/bb_cdr_pkg.sv
// Shared definitions for the bang-bang CDR datapath (PD, loop filter, PI).
// Contents:
//   bb_dir_t  - decimated window direction (none / up / down)
//   *_DEF     - default parameter values shared by the PD/PI wrappers
//   sat_add   - signed add with symmetric saturation to +/-(2^(w-1)-1)
package bb_cdr_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } bb_dir_t;

  localparam int DEC_LOG_DEF  = 2;
  localparam int FREQ_W_DEF   = 8;
  localparam int PHASE_W_DEF  = 6;
  localparam int FRAC_W_DEF   = 8;
  localparam int KP_SHIFT_DEF = 4;
  localparam int LOCK_THR_DEF = 8;

  // The clamp is symmetric (most negative code is never produced) so the
  // integral path has no bias toward the negative rail.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 w);
    logic signed [32:0] s;
    logic signed [32:0] lim;
    logic signed [32:0] nlim;
    s    = {a[31], a} + {b[31], b};
    lim  = (33'sd1 <<< (w - 1)) - 33'sd1;
    nlim = -lim;
    if (s > lim) begin
      sat_add = lim[31:0];
    end else if (s < nlim) begin
      sat_add = nlim[31:0];
    end else begin
      sat_add = s[31:0];
    end
  endfunction

endpackage

// File: rtl/bb_cdr_if.sv
// Vote/code bundle between the bang-bang PD, the loop filter and the PI.
//   UPb, DOWN, HOLD                  : PD votes (UPb active-low) and freeze request
//   PHASE_CODE, CODE_VALID           : PI code and its one-cycle update strobe
//   FREQ, LOCK, PD_ERR               : integral register, lock flag, PD conflict pulse
// master = vote source side, slave = loop filter side.
interface bb_cdr_if #(
  parameter int PHASE_W = bb_cdr_pkg::PHASE_W_DEF,
  parameter int FREQ_W  = bb_cdr_pkg::FREQ_W_DEF
);
  logic               UPb;
  logic               DOWN;
  logic               HOLD;
  logic [PHASE_W-1:0] PHASE_CODE;
  logic               CODE_VALID;
  logic [FREQ_W-1:0]  FREQ;
  logic               LOCK;
  logic               PD_ERR;

  modport master (
    output UPb, DOWN, HOLD,
    input  PHASE_CODE, CODE_VALID, FREQ, LOCK, PD_ERR
  );

  modport slave (
    input  UPb, DOWN, HOLD,
    output PHASE_CODE, CODE_VALID, FREQ, LOCK, PD_ERR
  );
endinterface

// File: rtl/bb_vote_decimator.sv
// Decodes per-cycle PD votes and sums them over a 2^DEC_LOG cycle window.
//   clk, rst_n : clock, synchronous active-low reset
//   upb, down  : PD early (active-low) / late (active-high) votes
//   hold       : freeze window position and sum, drop votes
//   win_done   : high in the window-closing cycle (combinational)
//   dir        : sign of the window sum including this cycle's vote
//   pd_err     : registered pulse for a conflicting UPb=0/DOWN=1 vote
module bb_vote_decimator
  import bb_cdr_pkg::*;
#(
  parameter int DEC_LOG = DEC_LOG_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    upb,
  input  logic    down,
  input  logic    hold,
  output logic    win_done,
  output bb_dir_t dir,
  output logic    pd_err
);

  localparam int CNT_W = (DEC_LOG > 0) ? DEC_LOG : 1;
  localparam int SUM_W = DEC_LOG + 2;
  localparam logic [CNT_W-1:0]        WIN_LAST = CNT_W'((64'd1 << DEC_LOG) - 64'd1);
  localparam logic signed [SUM_W-1:0] V_POS    = SUM_W'(32'sd1);
  localparam logic signed [SUM_W-1:0] V_NEG    = -V_POS;

  logic [CNT_W-1:0]        win_cnt_q, win_cnt_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [SUM_W-1:0] vote;
  logic signed [SUM_W-1:0] sum_tot;
  logic                    pd_err_q, pd_err_d;

  // Vote decode, window sum and next-state for counter/sum/PD_ERR.
  always_comb begin
    case ({upb, down})
      2'b00:   vote = V_POS;
      2'b11:   vote = V_NEG;
      default: vote = '0;    // idle, or conflicting vote which counts as 0
    endcase
    sum_tot  = sum_q + vote;
    // With DEC_LOG=0 the counter is pinned at 0 so every cycle closes.
    win_done = !hold && (win_cnt_q == WIN_LAST);
    if (sum_tot == '0) begin
      dir = DIR_NONE;
    end else if (sum_tot[SUM_W-1]) begin
      dir = DIR_DN;
    end else begin
      dir = DIR_UP;
    end
    pd_err_d = !hold && !upb && down;
    if (hold) begin
      win_cnt_d = win_cnt_q;
      sum_d     = sum_q;
    end else if (win_done) begin
      win_cnt_d = '0;
      sum_d     = '0;
    end else begin
      win_cnt_d = win_cnt_q + CNT_W'(1'b1);
      sum_d     = sum_tot;
    end
  end

  // Window state and PD_ERR registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
      sum_q     <= '0;
      pd_err_q  <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      sum_q     <= sum_d;
      pd_err_q  <= pd_err_d;
    end
  end

  assign pd_err = pd_err_q;

endmodule

// File: rtl/bb_cdr_loop_filter.sv
// Second-order bang-bang CDR loop filter: proportional step plus saturating
// integral into a wrapping phase accumulator, with a reversal-count lock flag.
//   CLK, RSTb : clock, synchronous active-low reset
//   VDD, VSS  : supply pins, no logic function
//   bus       : bb_cdr_if slave (votes/HOLD in, PHASE_CODE/CODE_VALID/FREQ/LOCK/PD_ERR out)
module bb_cdr_loop_filter
  import bb_cdr_pkg::*;
#(
  parameter int DEC_LOG  = DEC_LOG_DEF,
  parameter int FREQ_W   = FREQ_W_DEF,
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int KP_SHIFT = KP_SHIFT_DEF,
  parameter int LOCK_THR = LOCK_THR_DEF
) (
  input  logic  CLK,
  input  logic  RSTb,
  inout  wire   VDD,
  inout  wire   VSS,
  bb_cdr_if.slave bus
);

  localparam int AW     = PHASE_W + FRAC_W;
  localparam int LCNT_W = $clog2(LOCK_THR + 1);
  localparam logic [AW-1:0]     KP_STEP    = {{(AW-1){1'b0}}, 1'b1} << KP_SHIFT;
  localparam logic [LCNT_W-1:0] LOCK_THR_C = LCNT_W'(LOCK_THR);

  wire unused_supply = VDD ^ VSS;

  logic                     win_done;
  bb_dir_t                  win_dir;
  logic                     pd_err;

  logic [AW-1:0]            acc_q, acc_d;
  logic signed [FREQ_W-1:0] freq_q, freq_d;
  logic [LCNT_W-1:0]        lock_cnt_q, lock_cnt_d;
  bb_dir_t                  prev_dir_q, prev_dir_d;
  logic                     lock_q, lock_d;
  logic                     code_valid_q, code_valid_d;

  logic [AW-1:0]            step;
  logic [AW-1:0]            freq_ext;
  logic signed [31:0]       dir_i;
  logic signed [31:0]       freq_sum;

  bb_vote_decimator #(
    .DEC_LOG (DEC_LOG)
  ) u_dec (
    .clk      (CLK),
    .rst_n    (RSTb),
    .upb      (bus.UPb),
    .down     (bus.DOWN),
    .hold     (bus.HOLD),
    .win_done (win_done),
    .dir      (win_dir),
    .pd_err   (pd_err)
  );

  // Window update: accumulator uses FREQ before its own update this window.
  always_comb begin
    acc_d        = acc_q;
    freq_d       = freq_q;
    lock_cnt_d   = lock_cnt_q;
    prev_dir_d   = prev_dir_q;
    code_valid_d = win_done;
    step         = '0;
    dir_i        = 32'sd0;
    freq_sum     = 32'sd0;
    freq_ext     = AW'(freq_q);
    if (win_done) begin
      case (win_dir)
        DIR_UP: begin
          step  = KP_STEP;
          dir_i = 32'sd1;
        end
        DIR_DN: begin
          step  = -KP_STEP;
          dir_i = -32'sd1;
        end
        default: begin
          step  = '0;
          dir_i = 32'sd0;
        end
      endcase
      // Natural AW-bit wrap gives the modular phase behaviour in both directions.
      acc_d    = acc_q + step + freq_ext;
      freq_sum = sat_add(32'(freq_q), dir_i, FREQ_W);
      freq_d   = freq_sum[FREQ_W-1:0];
      // Tie windows carry no direction information and leave lock state alone.
      if (win_dir != DIR_NONE) begin
        if ((prev_dir_q != DIR_NONE) && (win_dir != prev_dir_q)) begin
          if (lock_cnt_q != LOCK_THR_C) begin
            lock_cnt_d = lock_cnt_q + LCNT_W'(1'b1);
          end else begin
            lock_cnt_d = lock_cnt_q;
          end
        end else begin
          lock_cnt_d = '0;
        end
        prev_dir_d = win_dir;
      end else begin
        prev_dir_d = prev_dir_q;
      end
    end else begin
      acc_d = acc_q;
    end
    lock_d = (lock_cnt_d >= LOCK_THR_C);
  end

  // Loop filter state and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      acc_q        <= '0;
      freq_q       <= '0;
      lock_cnt_q   <= '0;
      prev_dir_q   <= DIR_NONE;
      lock_q       <= 1'b0;
      code_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      freq_q       <= freq_d;
      lock_cnt_q   <= lock_cnt_d;
      prev_dir_q   <= prev_dir_d;
      lock_q       <= lock_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign bus.PHASE_CODE = acc_q[AW-1:FRAC_W];
  assign bus.FREQ       = freq_q;
  assign bus.LOCK       = lock_q;
  assign bus.CODE_VALID = code_valid_q;
  assign bus.PD_ERR     = pd_err;

endmodule

// File: tb/tb_bb_cdr_loop_filter.sv
// Scoreboard bench for bb_cdr_loop_filter at default parameters
// (window 4 cycles, 14-bit accumulator, code LSB = 256, KP step = 16).
module tb_bb_cdr_loop_filter;

  logic CLK = 1'b0;
  logic RSTb;
  wire  VDD;
  wire  VSS;
  assign VDD = 1'b1;
  assign VSS = 1'b0;

  bb_cdr_if #(.PHASE_W(6), .FREQ_W(8)) bus ();

  bb_cdr_loop_filter #(
    .DEC_LOG(2), .FREQ_W(8), .PHASE_W(6), .FRAC_W(8), .KP_SHIFT(4), .LOCK_THR(8)
  ) dut (
    .CLK  (CLK),
    .RSTb (RSTb),
    .VDD  (VDD),
    .VSS  (VSS),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int code;
    int freq;
    int lock;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model state (plain integer arithmetic)
  int   m_acc, m_freq, m_prev, m_lcnt, m_lock, m_wcnt, m_sum;
  logic m_cv, m_pderr;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_freq = 0; m_prev = 0; m_lcnt = 0; m_lock = 0;
    m_wcnt = 0; m_sum = 0; m_cv = 1'b0; m_pderr = 1'b0;
  endtask

  // One clock of stimulus; predicts window results into the scoreboard.
  task automatic step(input logic upb, input logic down, input logic hold);
    int v;
    int dir;
    bus.UPb = upb; bus.DOWN = down; bus.HOLD = hold;
    m_cv    = 1'b0;
    m_pderr = !hold && !upb && down;
    if (!hold) begin
      v = (!upb && !down) ? 1 : ((upb && down) ? -1 : 0);
      m_sum += v;
      if (m_wcnt == 3) begin
        dir   = (m_sum > 0) ? 1 : ((m_sum < 0) ? -1 : 0);
        m_acc = ((m_acc + dir * 16 + m_freq) % 16384 + 16384) % 16384;
        m_freq += dir;
        if (m_freq > 127)  m_freq = 127;
        if (m_freq < -127) m_freq = -127;
        if (dir != 0) begin
          if (m_prev != 0 && dir != m_prev) begin
            if (m_lcnt < 8) m_lcnt++;
          end else begin
            m_lcnt = 0;
          end
          m_prev = dir;
        end
        m_lock = (m_lcnt >= 8) ? 1 : 0;
        m_cv   = 1'b1;
        sb_q.push_back('{m_acc / 256, m_freq, m_lock});
        m_sum  = 0;
        m_wcnt = 0;
      end else begin
        m_wcnt++;
      end
    end
    @(posedge CLK); #1;
    chk("code_valid", int'(bus.CODE_VALID), int'(m_cv));
    chk("pd_err", int'(bus.PD_ERR), int'(m_pderr));
  endtask

  task automatic win_up();
    repeat (4) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic win_dn();
    repeat (4) step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    RSTb = 1'b0; bus.UPb = 1'b1; bus.DOWN = 1'b0; bus.HOLD = 1'b0;
    repeat (n) begin
      @(posedge CLK); #1;
    end
    model_reset();
    chk("rst_code", int'(bus.PHASE_CODE), 0);
    chk("rst_freq", int'($signed(bus.FREQ)), 0);
    chk("rst_lock", int'(bus.LOCK), 0);
    chk("rst_valid", int'(bus.CODE_VALID), 0);
    chk("rst_pderr", int'(bus.PD_ERR), 0);
    RSTb = 1'b1;
  endtask

  // Monitor: every CODE_VALID pulse is matched against the oldest prediction.
  always @(negedge CLK) begin
    if (bus.CODE_VALID === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got CODE_VALID=1 expected 0 at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_code", int'(bus.PHASE_CODE), mon_e.code);
        chk("sb_freq", int'($signed(bus.FREQ)), mon_e.freq);
        chk("sb_lock", int'(bus.LOCK), mon_e.lock);
      end
    end
  end

  int f1[4] = '{1, 2, 3, 4};

  initial begin
    RSTb = 1'b0; bus.UPb = 1'b1; bus.DOWN = 1'b0; bus.HOLD = 1'b0;
    model_reset();

    // 1: constant UP after a 3-cycle reset
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      win_up();
      chk("t1_freq", int'($signed(bus.FREQ)), f1[i]);
      chk("t1_code", int'(bus.PHASE_CODE), 0);
    end

    // 2: one DOWN window from reset wraps the accumulator to 16368
    do_reset(1);
    win_dn();
    chk("t2_code", int'(bus.PHASE_CODE), 63);
    chk("t2_freq", int'($signed(bus.FREQ)), -1);

    // 3/5: alternating windows reach LOCK; a tie window leaves it; repeat UP clears it
    do_reset(1);
    for (int i = 1; i <= 9; i++) begin
      if (i % 2 == 1) win_up(); else win_dn();
      chk("t3_freq", int'($signed(bus.FREQ)), (i % 2 == 1) ? 1 : 0);
      chk("t3_lock", int'(bus.LOCK), (i == 9) ? 1 : 0);
    end
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    chk("t5_tie_freq", int'($signed(bus.FREQ)), 1);
    chk("t5_tie_lock", int'(bus.LOCK), 1);
    win_up();
    chk("t3_unlock", int'(bus.LOCK), 0);
    chk("t3_freq10", int'($signed(bus.FREQ)), 2);

    // 5: conflicting vote pulses PD_ERR for one cycle and counts as 0
    step(1'b0, 1'b1, 1'b0);
    chk("t5_pderr_hi", int'(bus.PD_ERR), 1);
    step(1'b1, 1'b0, 1'b0);
    chk("t5_pderr_lo", int'(bus.PD_ERR), 0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    chk("t5_freq", int'($signed(bus.FREQ)), 3);

    // 4: integral saturation in both directions with phase wrap
    do_reset(1);
    repeat (200) win_up();
    chk("t4_sat_pos", int'($signed(bus.FREQ)), 127);
    repeat (300) win_dn();
    chk("t4_sat_neg", int'($signed(bus.FREQ)), -127);

    // 6: HOLD at win_cnt=2 for 10 cycles with toggling votes
    do_reset(1);
    win_up();
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'(i % 2), 1'((i / 2) % 2), 1'b1);
      chk("t6_hold_freq", int'($signed(bus.FREQ)), 1);
      chk("t6_hold_code", int'(bus.PHASE_CODE), 0);
    end
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    chk("t6_resume_valid", int'(bus.CODE_VALID), 1);
    chk("t6_resume_freq", int'($signed(bus.FREQ)), 1);

    // 6: reset mid-window discards the partial window
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    do_reset(1);
    win_up();
    chk("t6_rst_freq", int'($signed(bus.FREQ)), 1);

    step(1'b1, 1'b0, 1'b0);
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
